// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC averaging path.
package adc_pkg;

    localparam int unsigned ADC_W                  = 12;
    localparam int unsigned ADC_AVG_LOG2_DEPTH_DEF = 4;

    // Window fill state.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFill  = 2'd1,
        StFull  = 2'd2
    } avg_state_e;

    // Running-sum width: enough headroom for DEPTH full-scale samples.
    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned log2_depth);
        return data_w + log2_depth;
    endfunction

endpackage

// File: rtl/adc_avg_filter_if.sv
// Sample-in / average-out bus between the XADC capture stage and the display path.
interface adc_avg_filter_if #(
    parameter int unsigned DATA_W = adc_pkg::ADC_W
);
    logic              clear;
    logic              sample_valid;
    logic [DATA_W-1:0] sample;
    logic              avg_valid;
    logic [DATA_W-1:0] avg_value;
    logic              filled;

    // Upstream producer / downstream consumer side.
    modport master (
        output clear, sample_valid, sample,
        input  avg_valid, avg_value, filled
    );

    // Filter side.
    modport slave (
        input  clear, sample_valid, sample,
        output avg_valid, avg_value, filled
    );
endinterface

// File: rtl/adc_sample_ring.sv
// Circular sample buffer; evict_o is the entry the next write will overwrite.
module adc_sample_ring
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W     = ADC_W,
    parameter int unsigned LOG2_DEPTH = ADC_AVG_LOG2_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear_i,
    input  logic              wr_en_i,
    input  logic              fill_all_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] evict_o
);
    localparam int unsigned Depth = 1 << LOG2_DEPTH;

    logic [DATA_W-1:0]     mem_q [Depth];
    logic [DATA_W-1:0]     mem_d [Depth];
    logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;

    assign evict_o = mem_q[ptr_q];

    // Next-state: clear zeroes the window, fill_all replicates one sample everywhere.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        if (clear_i) begin
            for (int i = 0; i < int'(Depth); i++) mem_d[i] = '0;
            ptr_d = '0;
        end else if (wr_en_i) begin
            if (fill_all_i) begin
                for (int i = 0; i < int'(Depth); i++) mem_d[i] = wr_data_i;
            end else begin
                mem_d[ptr_q] = wr_data_i;
            end
            ptr_d = ptr_q + 1'b1;  // wraps naturally at Depth
        end
    end

    // Buffer and pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
            ptr_q <= '0;
        end else begin
            mem_q <= mem_d;
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adc_avg_filter.sv
// Boxcar moving average over the last 2^LOG2_DEPTH ADC samples.
// Optional build macro ADC_AVG_PRIME_EN: first sample after reset/clear primes the whole window.
module adc_avg_filter
    import adc_pkg::*;
#(
    parameter int unsigned DATA_W     = ADC_W,
    parameter int unsigned LOG2_DEPTH = ADC_AVG_LOG2_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    adc_avg_filter_if.slave         bus_io
);
    localparam int unsigned Depth = 1 << LOG2_DEPTH;
    localparam int unsigned SumW  = sum_w(DATA_W, LOG2_DEPTH);
    localparam int unsigned CntW  = LOG2_DEPTH + 1;

`ifdef ADC_AVG_PRIME_EN
    localparam bit PrimeEn = 1'b1;
`else
    localparam bit PrimeEn = 1'b0;
`endif

    avg_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [SumW-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0] avg_q, avg_d;
    logic              valid_q, valid_d;
    logic              filled_q, filled_d;

    logic              accept;
    logic              prime;
    logic [DATA_W-1:0] evict;
    logic [SumW-1:0]   sample_ext;

    assign accept     = bus_io.sample_valid & ~bus_io.clear;
    assign prime      = PrimeEn && accept && (state_q == StEmpty);
    assign sample_ext = SumW'(bus_io.sample);

    adc_sample_ring #(
        .DATA_W     (DATA_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk        (clk),
        .rstn       (rstn),
        .clear_i    (bus_io.clear),
        .wr_en_i    (accept),
        .fill_all_i (prime),
        .wr_data_i  (bus_io.sample),
        .evict_o    (evict)
    );

    // Next-state: running sum, fill FSM and output registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        avg_d    = avg_q;
        valid_d  = 1'b0;
        filled_d = filled_q;
        if (bus_io.clear) begin
            state_d  = StEmpty;
            cnt_d    = '0;
            sum_d    = '0;
            avg_d    = '0;
            filled_d = 1'b0;
        end else if (accept) begin
            // Evicted sample is already part of the sum, so this cannot underflow.
            sum_d   = prime ? (sample_ext << LOG2_DEPTH) : (sum_q + sample_ext - SumW'(evict));
            avg_d   = DATA_W'(sum_d >> LOG2_DEPTH);
            valid_d = 1'b1;
            unique case (state_q)
                StEmpty: begin
                    if (prime) begin
                        state_d = StFull;
                        cnt_d   = CntW'(Depth);
                    end else begin
                        state_d = StFill;
                        cnt_d   = CntW'(1);
                    end
                end
                StFill: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntW'(Depth)) state_d = StFull;
                end
                StFull:  state_d = StFull;
                default: state_d = StEmpty;
            endcase
            filled_d = (state_d == StFull);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StEmpty;
            cnt_q    <= '0;
            sum_q    <= '0;
            avg_q    <= '0;
            valid_q  <= 1'b0;
            filled_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            avg_q    <= avg_d;
            valid_q  <= valid_d;
            filled_q <= filled_d;
        end
    end

    assign bus_io.avg_valid = valid_q;
    assign bus_io.avg_value = avg_q;
    assign bus_io.filled    = filled_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Self-checking bench for adc_avg_filter (DATA_W=12, LOG2_DEPTH=4).
module tb_adc_avg_filter;

`ifdef ADC_AVG_PRIME_EN
    localparam bit PRIME = 1'b1;
`else
    localparam bit PRIME = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] avg;
        logic        filled;
    } exp_t;

    logic clk;
    logic rstn;

    adc_avg_filter_if #(.DATA_W(12)) bus ();

    adc_avg_filter #(
        .DATA_W     (12),
        .LOG2_DEPTH (4)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors  = 0;
    int   valid_cnt = 0;
    exp_t exp_q[$];

    // Reference window model.
    int m_buf[16];
    int m_sum;
    int m_ptr;
    int m_cnt;

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_buf[i] = 0;
        m_sum = 0;
        m_ptr = 0;
        m_cnt = 0;
    endfunction

    function automatic void model_accept(input int s);
        exp_t e;
        if (PRIME && m_cnt == 0) begin
            for (int i = 0; i < 16; i++) m_buf[i] = s;
            m_sum = s * 16;
            m_cnt = 16;
        end else begin
            m_sum = m_sum + s - m_buf[m_ptr];
            m_buf[m_ptr] = s;
            if (m_cnt < 16) m_cnt++;
        end
        m_ptr = (m_ptr + 1) % 16;
        e.avg    = 12'(m_sum >> 4);
        e.filled = (m_cnt == 16);
        exp_q.push_back(e);
    endfunction

    // Scoreboard: every avg_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (bus.avg_valid === 1'b1) begin
            valid_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_spurious: avg_valid with no pending sample, avg_value=%0d",
                         bus.avg_value);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.avg_value !== e.avg || bus.filled !== e.filled) begin
                    errors++;
                    $display("FAIL scoreboard: got avg=%0d filled=%b, want avg=%0d filled=%b",
                             bus.avg_value, bus.filled, e.avg, e.filled);
                end
            end
        end
    end

    task automatic pulse(input int s);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample       = 12'(s);
        model_accept(s);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        #1;
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        model_clear();
        @(negedge clk);
        bus.clear = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rstn             = 1'b0;
        bus.clear        = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        model_clear();
        #1;
        vectors++;
        if (bus.avg_valid !== 1'b0 || bus.avg_value !== 12'd0 || bus.filled !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b avg=%0d filled=%b, want 0/0/0",
                     bus.avg_valid, bus.avg_value, bus.filled);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_fill();
        int c0;
        c0 = valid_cnt;
        pulse(1600);
        vectors++;
        if (bus.avg_value !== 12'd100 || bus.filled !== 1'b0) begin
            errors++;
            $display("FAIL fill_first: got avg=%0d filled=%b, want 100/0", bus.avg_value, bus.filled);
        end
        for (int i = 1; i < 16; i++) pulse(1600);
        vectors++;
        if (bus.avg_value !== 12'd1600 || bus.filled !== 1'b1) begin
            errors++;
            $display("FAIL fill_last: got avg=%0d filled=%b, want 1600/1", bus.avg_value, bus.filled);
        end
        vectors++;
        if (valid_cnt - c0 !== 16) begin
            errors++;
            $display("FAIL fill_valid_count: got %0d, want 16", valid_cnt - c0);
        end
        // Idle cycle: no strobe, value held.
        @(negedge clk);
        #1;
        vectors++;
        if (bus.avg_valid !== 1'b0 || bus.avg_value !== 12'd1600) begin
            errors++;
            $display("FAIL idle_hold: got valid=%b avg=%0d, want 0/1600", bus.avg_valid, bus.avg_value);
        end
    endtask

    task automatic test_wrap();
        do_clear();
        for (int i = 0; i < 16; i++) pulse(4095);
        for (int i = 0; i < 8; i++) pulse(0);
        vectors++;
        if (bus.avg_value !== 12'd2047 || bus.filled !== 1'b1) begin
            errors++;
            $display("FAIL wrap_half: got avg=%0d filled=%b, want 2047/1", bus.avg_value, bus.filled);
        end
        for (int i = 0; i < 8; i++) pulse(0);
        vectors++;
        if (bus.avg_value !== 12'd0 || bus.filled !== 1'b1) begin
            errors++;
            $display("FAIL wrap_full: got avg=%0d filled=%b, want 0/1", bus.avg_value, bus.filled);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        do_clear();
        c0 = valid_cnt;
        @(negedge clk);
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.sample = 12'(i);
            model_accept(i);
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        #1;
        vectors++;
        if (valid_cnt - c0 !== 20) begin
            errors++;
            $display("FAIL b2b_valid_count: got %0d, want 20", valid_cnt - c0);
        end
        if (!PRIME) begin
            vectors++;
            if (bus.avg_value !== 12'd11) begin
                errors++;
                $display("FAIL b2b_final: got avg=%0d, want 11", bus.avg_value);
            end
        end
    endtask

    task automatic test_clear_collision();
        logic [11:0] want;
        do_clear();
        for (int i = 0; i < 16; i++) pulse(1000);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.clear        = 1'b1;
        bus.sample       = 12'd3000;
        model_clear();
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.clear        = 1'b0;
        #1;
        vectors++;
        if (bus.avg_value !== 12'd0 || bus.filled !== 1'b0 || bus.avg_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_collision: got avg=%0d filled=%b valid=%b, want 0/0/0",
                     bus.avg_value, bus.filled, bus.avg_valid);
        end
        pulse(3000);
        want = PRIME ? 12'd3000 : 12'd187;
        vectors++;
        if (bus.avg_value !== want) begin
            errors++;
            $display("FAIL clear_next_sample: got avg=%0d, want %0d", bus.avg_value, want);
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] want;
        for (int i = 0; i < 5; i++) pulse(2000);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if (bus.avg_valid !== 1'b0 || bus.avg_value !== 12'd0 || bus.filled !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b avg=%0d filled=%b, want 0/0/0",
                     bus.avg_valid, bus.avg_value, bus.filled);
        end
        model_clear();
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        pulse(1600);
        want = PRIME ? 12'd1600 : 12'd100;
        vectors++;
        if (bus.avg_value !== want || bus.filled !== PRIME) begin
            errors++;
            $display("FAIL reset_recovery: got avg=%0d filled=%b, want %0d/%b",
                     bus.avg_value, bus.filled, want, PRIME);
        end
    endtask

    task automatic test_prime();
        do_clear();
        pulse(2500);
        vectors++;
        if (bus.avg_value !== 12'd2500 || bus.filled !== 1'b1) begin
            errors++;
            $display("FAIL prime_first: got avg=%0d filled=%b, want 2500/1", bus.avg_value, bus.filled);
        end
        pulse(0);
        vectors++;
        if (bus.avg_value !== 12'd2343) begin
            errors++;
            $display("FAIL prime_second: got avg=%0d, want 2343", bus.avg_value);
        end
    endtask

    initial begin
        test_reset();
`ifdef ADC_AVG_PRIME_EN
        test_prime();
`else
        test_fill();
        test_wrap();
`endif
        test_back_to_back();
        test_clear_collision();
        test_async_reset();
        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
